// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, START/BUSY/DONE handshake.
// Results and the divide-by-zero flag are held until the next accepted request.
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             BUSY,
    output logic             DONE,
    output logic             DZ
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] div_q,   div_d;
    logic [WIDTH-1:0] rem_q,   rem_d;
    logic [WIDTH-1:0] quo_q,   quo_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] q_q,     q_d;
    logic [WIDTH-1:0] r_q,     r_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic             dz_q,    dz_d;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;

    // quo_q starts as the dividend, so its MSB is the next dividend bit to shift in.
    // The shifted remainder needs WIDTH+1 bits since it can reach 2*B-1.
    always_comb begin
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        trial     = rem_shift - {1'b0, div_q};
        if (trial[WIDTH]) begin
            rem_step = rem_shift[WIDTH-1:0];
        end else begin
            rem_step = trial[WIDTH-1:0];
        end
        quo_step = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dz_d    = dz_q;

        case (state_q)
            IDLE, FIN: begin
                if (START) begin
                    div_d = B;
                    rem_d = '0;
                    quo_d = A;
                    cnt_d = '0;
                    dz_d  = 1'b0;
                    if (B != '0) begin
                        state_d = CALC;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = FIN;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        q_d     = {WIDTH{1'b1}};
                        r_d     = A;
                        dz_d    = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            CALC: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q + CNT_W'(1);
                // The last step publishes straight to Q/R so DONE and the result coincide.
                if (cnt_q == LAST_STEP) begin
                    state_d = FIN;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    q_d     = quo_step;
                    r_d     = rem_step;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            div_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign Q    = q_q;
    assign R    = r_q;
    assign BUSY = busy_q;
    assign DONE = done_q;
    assign DZ   = dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider at WIDTH=4 and WIDTH=8 against a plain-arithmetic divide model.
module tb_seq_divider;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic [3:0] q4, r4;
    logic       busy4, done4, dz4;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic [7:0] q8, r8;
    logic       busy8, done8, dz8;

    int n_vec = 0;
    int n_err = 0;

    seq_divider #(.WIDTH(4)) dut4 (
        .CLK(clk), .RST_N(rst_n), .START(start4), .A(a4), .B(b4),
        .Q(q4), .R(r4), .BUSY(busy4), .DONE(done4), .DZ(dz4)
    );

    seq_divider #(.WIDTH(8)) dut8 (
        .CLK(clk), .RST_N(rst_n), .START(start8), .A(a8), .B(b8),
        .Q(q8), .R(r8), .BUSY(busy8), .DONE(done8), .DZ(dz8)
    );

    always #5 clk = ~clk;

    function automatic int unsigned ref_q(input int unsigned a, input int unsigned b, input int w);
        return (b == 0) ? ((1 << w) - 1) : (a / b);
    endfunction

    function automatic int unsigned ref_r(input int unsigned a, input int unsigned b);
        return (b == 0) ? a : (a % b);
    endfunction

    // Present an operation, let the accepting edge pass, then scramble A/B.
    task automatic start4_op(input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        a4 = a; b4 = b; start4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
    endtask

    task automatic wait4(output int edges, output logic got);
        edges = 1;
        while (!done4 && edges < 30) begin
            @(posedge clk);
            @(negedge clk);
            edges++;
        end
        got = done4;
    endtask

    task automatic start8_op(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        a8 = a; b8 = b; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    endtask

    task automatic wait8(output int edges, output logic got);
        edges = 1;
        while (!done8 && edges < 30) begin
            @(posedge clk);
            @(negedge clk);
            edges++;
        end
        got = done8;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        n_vec++;
        if ({q4, r4, busy4, done4, dz4} !== 11'd0) begin
            n_err++; $display("FAIL reset_w4: got %h want 0", {q4, r4, busy4, done4, dz4});
        end
        n_vec++;
        if ({q8, r8, busy8, done8, dz8} !== 19'd0) begin
            n_err++; $display("FAIL reset_w8: got %h want 0", {q8, r8, busy8, done8, dz8});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        start4_op(4'd13, 4'd4);
        for (int e = 1; e <= 4; e++) begin
            n_vec++;
            if ({busy4, done4, q4, r4} !== {1'b1, 1'b0, 4'd0, 4'd0}) begin
                n_err++; $display("FAIL basic_calc edge%0d: got busy=%b done=%b q=%0d r=%0d want busy=1 done=0 q=0 r=0",
                                  e, busy4, done4, q4, r4);
            end
            @(posedge clk);
            @(negedge clk);
        end
        n_vec++;
        if ({busy4, done4, q4, r4, dz4} !== {1'b0, 1'b1, 4'd3, 4'd1, 1'b0}) begin
            n_err++; $display("FAIL basic_done: got busy=%b done=%b q=%0d r=%0d dz=%b want 0 1 3 1 0",
                              busy4, done4, q4, r4, dz4);
        end
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({busy4, done4, q4, r4} !== {1'b0, 1'b0, 4'd3, 4'd1}) begin
            n_err++; $display("FAIL basic_hold: got busy=%b done=%b q=%0d r=%0d want 0 0 3 1", busy4, done4, q4, r4);
        end
    endtask

    task automatic test_table();
        logic [3:0] ta [5] = '{4'd15, 4'd3, 4'd0, 4'd7, 4'd8};
        logic [3:0] tb [5] = '{4'd1,  4'd9, 4'd5, 4'd7, 4'd15};
        int   edges;
        logic got;
        for (int i = 0; i < 5; i++) begin
            start4_op(ta[i], tb[i]);
            wait4(edges, got);
            n_vec++;
            if ({got, q4, r4, dz4} !== {1'b1, 4'(ref_q(ta[i], tb[i], 4)), 4'(ref_r(ta[i], tb[i])), 1'b0}) begin
                n_err++; $display("FAIL table %0d/%0d: got done=%b q=%0d r=%0d dz=%b want q=%0d r=%0d",
                                  ta[i], tb[i], got, q4, r4, dz4, ref_q(ta[i], tb[i], 4), ref_r(ta[i], tb[i]));
            end
        end
    endtask

    task automatic test_div_zero();
        int   edges;
        logic got;
        start4_op(4'd7, 4'd0);
        n_vec++;
        if ({done4, busy4, q4, r4, dz4} !== {1'b1, 1'b0, 4'd15, 4'd7, 1'b1}) begin
            n_err++; $display("FAIL dz_result: got done=%b busy=%b q=%0d r=%0d dz=%b want 1 0 15 7 1",
                              done4, busy4, q4, r4, dz4);
        end
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({done4, q4, r4, dz4} !== {1'b0, 4'd15, 4'd7, 1'b1}) begin
            n_err++; $display("FAIL dz_hold: got done=%b q=%0d r=%0d dz=%b want 0 15 7 1", done4, q4, r4, dz4);
        end
        start4_op(4'd6, 4'd3);
        n_vec++;
        if ({busy4, dz4} !== 2'b10) begin
            n_err++; $display("FAIL dz_clear: got busy=%b dz=%b want busy=1 dz=0", busy4, dz4);
        end
        wait4(edges, got);
        n_vec++;
        if ({got, q4, r4, dz4} !== {1'b1, 4'd2, 4'd0, 1'b0} || edges != 5) begin
            n_err++; $display("FAIL dz_next: got done=%b q=%0d r=%0d dz=%b edges=%0d want 1 2 0 0 edges=5",
                              got, q4, r4, dz4, edges);
        end
    endtask

    task automatic test_ignore_start();
        int   edges;
        logic got;
        start4_op(4'd9, 4'd2);
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b1; a4 = 4'd1; b4 = 4'd1;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0;
        wait4(edges, got);
        edges += 3;
        n_vec++;
        if ({got, q4, r4, dz4} !== {1'b1, 4'd4, 4'd1, 1'b0} || edges != 5) begin
            n_err++; $display("FAIL ignore_start: got done=%b q=%0d r=%0d dz=%b edges=%0d want 1 4 1 0 edges=5",
                              got, q4, r4, dz4, edges);
        end
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({busy4, done4} !== 2'b00) begin
            n_err++; $display("FAIL ignore_idle: got busy=%b done=%b want 0 0", busy4, done4);
        end
    endtask

    task automatic test_back_to_back();
        int   edges;
        logic got;
        start4_op(4'd11, 4'd5);
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b1; a4 = 4'd14; b4 = 4'd3;
        wait4(edges, got);
        n_vec++;
        if ({got, q4, r4} !== {1'b1, 4'd2, 4'd1}) begin
            n_err++; $display("FAIL b2b_first: got done=%b q=%0d r=%0d want 1 2 1", got, q4, r4);
        end
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
        n_vec++;
        if ({busy4, done4, q4, r4} !== {1'b1, 1'b0, 4'd2, 4'd1}) begin
            n_err++; $display("FAIL b2b_accept: got busy=%b done=%b q=%0d r=%0d want 1 0 2 1", busy4, done4, q4, r4);
        end
        wait4(edges, got);
        n_vec++;
        if ({got, q4, r4, dz4} !== {1'b1, 4'd4, 4'd2, 1'b0} || edges != 5) begin
            n_err++; $display("FAIL b2b_second: got done=%b q=%0d r=%0d dz=%b edges=%0d want 1 4 2 0 edges=5",
                              got, q4, r4, dz4, edges);
        end
    endtask

    task automatic test_reset_mid();
        int   edges;
        logic got;
        logic saw_done;
        start4_op(4'd13, 4'd4);
        @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({q4, r4, busy4, done4, dz4} !== 11'd0) begin
            n_err++; $display("FAIL reset_mid: got q=%0d r=%0d busy=%b done=%b dz=%b want all 0",
                              q4, r4, busy4, done4, dz4);
        end
        saw_done = 1'b0;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 2) rst_n = 1'b1;
            saw_done |= done4;
        end
        n_vec++;
        if (saw_done !== 1'b0) begin
            n_err++; $display("FAIL reset_abort: got done seen=%b want 0", saw_done);
        end
        start4_op(4'd10, 4'd3);
        wait4(edges, got);
        n_vec++;
        if ({got, q4, r4, dz4} !== {1'b1, 4'd3, 4'd1, 1'b0} || edges != 5) begin
            n_err++; $display("FAIL reset_recover: got done=%b q=%0d r=%0d dz=%b edges=%0d want 1 3 1 0 edges=5",
                              got, q4, r4, dz4, edges);
        end
    endtask

    task automatic test_random_w4();
        int   edges;
        logic got;
        logic [3:0] a, b;
        for (int i = 0; i < 30; i++) begin
            a = 4'($urandom);
            b = 4'($urandom);
            start4_op(a, b);
            wait4(edges, got);
            n_vec++;
            if ({got, q4, r4, dz4} !== {1'b1, 4'(ref_q(a, b, 4)), 4'(ref_r(a, b)), b == 4'd0}
                || edges != ((b == 4'd0) ? 1 : 5)) begin
                n_err++; $display("FAIL rand_w4 %0d/%0d: got done=%b q=%0d r=%0d dz=%b edges=%0d want q=%0d r=%0d",
                                  a, b, got, q4, r4, dz4, edges, ref_q(a, b, 4), ref_r(a, b));
            end
        end
    endtask

    task automatic test_w8_latency();
        int   edges;
        logic got;
        start8_op(8'd255, 8'd16);
        wait8(edges, got);
        n_vec++;
        if ({got, q8, r8, dz8} !== {1'b1, 8'd15, 8'd15, 1'b0} || edges != 9) begin
            n_err++; $display("FAIL w8_latency: got done=%b q=%0d r=%0d dz=%b edges=%0d want 1 15 15 0 edges=9",
                              got, q8, r8, dz8, edges);
        end
    endtask

    task automatic test_random_w8();
        int   edges;
        logic got;
        logic [7:0] a, b;
        for (int i = 0; i < 60; i++) begin
            a = 8'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255) >> $urandom_range(0, 7));
            start8_op(a, b);
            wait8(edges, got);
            n_vec++;
            if ({got, q8, r8, dz8} !== {1'b1, 8'(ref_q(a, b, 8)), 8'(ref_r(a, b)), b == 8'd0}
                || edges != ((b == 8'd0) ? 1 : 9)) begin
                n_err++; $display("FAIL rand_w8 %0d/%0d: got done=%b q=%0d r=%0d dz=%b edges=%0d want q=%0d r=%0d",
                                  a, b, got, q8, r8, dz8, edges, ref_q(a, b, 8), ref_r(a, b));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_table();
        test_div_zero();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random_w4();
        test_w8_latency();
        test_random_w8();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
